mult_4x4_accum_ml4: RTL and testbench



---
 rtl/mult_4x4_accum_ml4.sv | 105 ++++++++++
 tb/tb_mult_4x4_accum_ml4.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_4x4_accum_ml4.sv
// Frame accumulator for the 4x4 multiplier product. It sums LEN beats and presents the result over valid/ready.
// Defining ACC_SAT_EN makes the accumulator saturate and report overflow on out_ovf.
module mult_4x4_accum_ml4 #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned LEN    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam logic [0:0] ACC  = 1'b0;
  localparam logic [0:0] DONE = 1'b1;
  localparam logic [7:0] LAST = 8'(LEN - 1);

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic [ACC_W-1:0] next_acc;
  logic             accept;
  logic             last;
  logic             fire;

  assign in_ready = (state == ACC) && !clear;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == LAST);
  assign fire     = out_valid && out_ready;
  assign busy     = (cnt != '0) || out_valid;

`ifdef ACC_SAT_EN
  localparam int unsigned SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] raw_sum;
  logic             frame_sat;
  logic             ovf_q;

  assign raw_sum  = {1'b0, acc} + SUM_W'(in_product);
  assign next_acc = raw_sum[ACC_W] ? '1 : raw_sum[ACC_W-1:0];
  assign out_ovf  = ovf_q;

  // frame_sat collects the saturation events of the frame in progress. It is handed to out_ovf when the last beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sat <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (clear) begin
      frame_sat <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      if (last) begin
        frame_sat <= 1'b0;
        ovf_q     <= frame_sat | raw_sum[ACC_W];
      end else begin
        frame_sat <= frame_sat | raw_sum[ACC_W];
      end
    end else if (fire) begin
      ovf_q <= 1'b0;
    end
  end
`else
  assign next_acc = acc + ACC_W'(in_product);
  assign out_ovf  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (clear) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (state == ACC) begin
      if (accept) begin
        if (last) begin
          out_sum   <= next_acc;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          state     <= DONE;
        end else begin
          acc <= next_acc;
          cnt <= cnt + 8'd1;
        end
      end
    end else if (fire) begin
      out_valid <= 1'b0;
      state     <= ACC;
    end
  end

endmodule

// File: tb/tb_mult_4x4_accum_ml4.sv
// Directed bench for mult_4x4_accum_ml4. It uses a per-cycle vector table plus hand-written reset, gap, ACC_W=9 and LEN=1 sequences.
module tb_mult_4x4_accum_ml4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_clr = 1'b0, a_vld = 1'b0, a_rdy = 1'b0;
  logic [7:0]  a_prod = '0;
  logic        a_ir, a_ov, a_ovf, a_busy;
  logic [11:0] a_sum;

  logic        b_vld = 1'b0, b_rdy = 1'b0;
  logic [7:0]  b_prod = '0;
  logic        b_ir, b_ov, b_ovf, b_busy;
  logic [8:0]  b_sum;

  logic        c_vld = 1'b0, c_rdy = 1'b0;
  logic [7:0]  c_prod = '0;
  logic        c_ir, c_ov, c_ovf, c_busy;
  logic [11:0] c_sum;

  logic        no_clear = 1'b0;

  mult_4x4_accum_ml4 #(.PROD_W(8), .ACC_W(12), .LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(a_clr), .in_valid(a_vld), .in_ready(a_ir),
    .in_product(a_prod), .out_valid(a_ov), .out_ready(a_rdy), .out_sum(a_sum),
    .out_ovf(a_ovf), .busy(a_busy));

  mult_4x4_accum_ml4 #(.PROD_W(8), .ACC_W(9), .LEN(4)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .clear(no_clear), .in_valid(b_vld), .in_ready(b_ir),
    .in_product(b_prod), .out_valid(b_ov), .out_ready(b_rdy), .out_sum(b_sum),
    .out_ovf(b_ovf), .busy(b_busy));

  mult_4x4_accum_ml4 #(.PROD_W(8), .ACC_W(12), .LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(no_clear), .in_valid(c_vld), .in_ready(c_ir),
    .in_product(c_prod), .out_valid(c_ov), .out_ready(c_rdy), .out_sum(c_sum),
    .out_ovf(c_ovf), .busy(c_busy));

  typedef struct {
    logic        clr;
    logic        vld;
    logic [7:0]  prod;
    logic        rdy;
    logic        exp_ir;
    logic        exp_ov;
    logic [11:0] exp_sum;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input logic clr, input logic vld, input int prod, input logic rdy,
                              input logic ir, input logic ov, input int sum, input logic bsy);
    vec_t v;
    v.clr = clr; v.vld = vld; v.prod = 8'(prod); v.rdy = rdy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_sum = 12'(sum); v.exp_busy = bsy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge. Outputs are sampled 1ns later, before the next rising edge.
  task automatic step(input logic clr, input logic vld, input int prod, input logic rdy);
    @(negedge clk);
    a_clr = clr; a_vld = vld; a_prod = 8'(prod); a_rdy = rdy;
    #1;
  endtask

  initial begin
    // Test 1: back-to-back 9,15,225,0, then a one-cycle in_ready bubble.
    add(0,1,9,1,    1,0,0,0);
    add(0,1,15,1,   1,0,0,1);
    add(0,1,225,1,  1,0,0,1);
    add(0,1,0,1,    1,0,0,1);
    add(0,0,0,1,    0,1,249,1);
    add(0,0,0,1,    1,0,249,0);
    // Test 2: 1,2,3,4 held under backpressure. A beat offered in DONE must be ignored.
    add(0,1,1,0,    1,0,249,0);
    add(0,1,2,0,    1,0,249,1);
    add(0,1,3,0,    1,0,249,1);
    add(0,1,4,0,    1,0,249,1);
    add(0,0,0,0,    0,1,10,1);
    add(0,1,77,0,   0,1,10,1);
    add(0,0,0,0,    0,1,10,1);
    add(0,0,0,0,    0,1,10,1);
    add(0,0,0,0,    0,1,10,1);
    add(0,0,0,1,    0,1,10,1);
    add(0,0,0,0,    1,0,10,0);
    // Test 4: clear with a beat present, then 1,1,1,1.
    add(0,1,50,0,   1,0,10,0);
    add(0,1,60,0,   1,0,10,1);
    add(1,1,99,0,   0,0,10,1);
    add(0,0,0,0,    1,0,10,0);
    add(0,1,1,0,    1,0,10,0);
    add(0,1,1,0,    1,0,10,1);
    add(0,1,1,0,    1,0,10,1);
    add(0,1,1,0,    1,0,10,1);
    add(0,0,0,1,    0,1,4,1);
    add(0,0,0,0,    1,0,4,0);
    // Clear while DONE drops the result but keeps out_sum.
    add(0,1,2,0,    1,0,4,0);
    add(0,1,2,0,    1,0,4,1);
    add(0,1,2,0,    1,0,4,1);
    add(0,1,2,0,    1,0,4,1);
    add(0,0,0,0,    0,1,8,1);
    add(1,0,0,1,    0,1,8,1);
    add(0,0,0,0,    1,0,8,0);

    // Reset state
    #2;
    chk("rst_out_valid", a_ov, 0);
    chk("rst_out_sum", a_sum, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ovf", a_ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", a_ir, 1);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].vld, vecs[i].prod, vecs[i].rdy);
      chk($sformatf("v%0d_in_ready", i), a_ir, vecs[i].exp_ir);
      chk($sformatf("v%0d_out_valid", i), a_ov, vecs[i].exp_ov);
      chk($sformatf("v%0d_out_sum", i), a_sum, vecs[i].exp_sum);
      chk($sformatf("v%0d_busy", i), a_busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_ovf", i), a_ovf, 0);
    end

    // Test 5: asynchronous reset while DONE, then while a frame is in progress.
    for (int i = 1; i <= 4; i++) step(0, 1, i, 0);
    step(0, 0, 0, 0);
    chk("t5_pre_valid", a_ov, 1);
    chk("t5_pre_sum", a_sum, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", a_ov, 0);
    chk("t5_async_sum", a_sum, 0);
    chk("t5_async_busy", a_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("t5_rel_in_ready", a_ir, 1);
    step(0, 1, 9, 0);
    step(0, 1, 9, 0);
    step(0, 0, 0, 0);
    chk("t5_mid_busy", a_busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("t5_mid_rst_busy", a_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1, 5, 0);
    step(0, 0, 0, 1);
    chk("t5_valid", a_ov, 1);
    chk("t5_sum", a_sum, 20);
    step(0, 0, 0, 0);
    chk("t5_after_hs", a_ov, 0);

    // Test 6: in_valid gaps between beats. No result may appear before the final beat is accepted.
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        step(0, 0, 0, 0);
        chk("t6_gap_valid", a_ov, 0);
      end
      step(0, 1, 7 + i, 0);
      chk("t6_beat_valid", a_ov, 0);
      chk("t6_beat_ready", a_ir, 1);
    end
    step(0, 0, 0, 1);
    chk("t6_valid", a_ov, 1);
    chk("t6_sum", a_sum, 34);
    step(0, 0, 0, 0);
    chk("t6_after_hs", a_ov, 0);

    // Test 3: ACC_W=9, four beats of 225 (wrap or saturate).
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_vld = 1'b1; b_prod = 8'd225; b_rdy = 1'b1;
    end
    @(negedge clk) b_vld = 1'b0;
    #1;
    chk("t3_valid", b_ov, 1);
    chk("t3_in_ready", b_ir, 0);
`ifdef ACC_SAT_EN
    chk("t3_sum", b_sum, 511);
    chk("t3_ovf", b_ovf, 1);
`else
    chk("t3_sum", b_sum, 388);
    chk("t3_ovf", b_ovf, 0);
`endif
    @(negedge clk);
    #1;
    chk("t3_after_hs_valid", b_ov, 0);
    chk("t3_after_hs_ovf", b_ovf, 0);
    chk("t3_after_hs_busy", b_busy, 0);

    // LEN=1: each beat becomes a result.
    @(negedge clk);
    c_vld = 1'b1; c_prod = 8'd77; c_rdy = 1'b0;
    #1 chk("len1_pre_valid", c_ov, 0);
    @(negedge clk) c_vld = 1'b0;
    #1;
    chk("len1_valid", c_ov, 1);
    chk("len1_sum", c_sum, 77);
    chk("len1_in_ready", c_ir, 0);
    chk("len1_ovf", c_ovf, 0);
    c_rdy = 1'b1;
    @(negedge clk);
    c_rdy = 1'b0; c_vld = 1'b1; c_prod = 8'd200;
    #1;
    chk("len1_bubble_gone", c_ir, 1);
    chk("len1_busy", c_busy, 0);
    @(negedge clk) c_vld = 1'b0;
    #1;
    chk("len1_valid2", c_ov, 1);
    chk("len1_sum2", c_sum, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
